// File: rtl/mod_hash_seq.sv
// Block-hash sequencer. It drives a SHA-256 compression core through the
// LOAD_H / HASH / SUM_STORE commands and serves the message, K and H words to it.
module mod_hash_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        M_WE,
  input  logic [3:0]  M_WA,
  input  logic [31:0] M_WD,
  input  logic [2:0]  H_RA,
  output logic [31:0] H_RD,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  CMD,
  input  logic [7:0]  MKA,
  input  logic [7:0]  HA,
  output logic [31:0] MD,
  output logic [31:0] KD,
  output logic [31:0] HD_IN,
  input  logic [31:0] HD_OUT,
  input  logic        RDY
);

  localparam logic [7:0] CmdIdle     = 8'd0;
  localparam logic [7:0] CmdLoadH    = 8'd1;
  localparam logic [7:0] CmdHash     = 8'd2;
  localparam logic [7:0] CmdSumStore = 8'd3;
  localparam logic [7:0] WdLast      = 8'd254;

  typedef enum logic [2:0] {
    StIdle, StLoadH, StGap1, StHash, StGap2, StSumStore, StFin
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wd_q, wd_d;
  logic        err_q, err_d;
  logic        rdy_q;
  logic        rdy_rise;
  logic [31:0] m_q [16];
  logic [31:0] h_q [16];   // H[8..23]
  logic [31:0] iv;

  assign rdy_rise = RDY & ~rdy_q;
  assign ERR      = err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      wd_q    <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      rdy_q   <= RDY;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = '0;
    err_d   = err_q;
    CMD     = CmdIdle;
    BUSY    = 1'b1;
    DONE    = 1'b0;
    unique case (state_q)
      StIdle: begin
        BUSY = 1'b0;
        if (START) begin
          state_d = StLoadH;
          err_d   = 1'b0;
        end
      end
      StLoadH: begin
        CMD = CmdLoadH;
        if (rdy_rise) begin
          state_d = StGap1;
        end else if (wd_q == WdLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      StGap1: state_d = StHash;
      StHash: begin
        CMD = CmdHash;
        if (rdy_rise) begin
          state_d = StGap2;
        end else if (wd_q == WdLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      StGap2: state_d = StSumStore;
      StSumStore: begin
        CMD = CmdSumStore;
        if (rdy_rise) begin
          state_d = StFin;
        end else if (wd_q == WdLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      StFin: begin
        BUSY    = 1'b0;
        DONE    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        BUSY    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Message buffer: host writes land only while idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) m_q[i] <= '0;
    end else if (M_WE && state_q == StIdle) begin
      m_q[M_WA] <= M_WD;
    end
  end

  // H RAM: the core stores summed words into H[8..15] during SUM_STORE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) h_q[i] <= '0;
    end else if (state_q == StSumStore && HA < 8'd8) begin
      h_q[{1'b0, HA[2:0]}] <= HD_OUT;
    end
  end

  always_comb begin
    iv = '0;
    unique case (HA[2:0])
      3'd0: iv = 32'h6a09e667;
      3'd1: iv = 32'hbb67ae85;
      3'd2: iv = 32'h3c6ef372;
      3'd3: iv = 32'ha54ff53a;
      3'd4: iv = 32'h510e527f;
      3'd5: iv = 32'h9b05688c;
      3'd6: iv = 32'h1f83d9ab;
      3'd7: iv = 32'h5be0cd19;
      default: iv = '0;
    endcase
  end

  // For HA in 8..23 the RAM index is HA-8, i.e. {HA[4], HA[2:0]}.
  always_comb begin
    if (HA < 8'd8) begin
      HD_IN = iv;
    end else if (HA < 8'd24) begin
      HD_IN = h_q[{HA[4], HA[2:0]}];
    end else begin
      HD_IN = '0;
    end
  end

  assign H_RD = h_q[{1'b0, H_RA}];
  assign MD   = m_q[MKA[3:0]];

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    logic [31:0] k;
    k = '0;
    case (idx)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      6'd63: k = 32'hc67178f2;
      default: k = '0;
    endcase
    return k;
  endfunction

  assign KD = (MKA < 8'd64) ? k_const(MKA[5:0]) : 32'd0;

endmodule

// File: tb/tb_mod_hash_seq.sv
// Directed bench for mod_hash_seq with a behavioural SHA-256 compression core
// that talks to the sequencer through its CMD/RDY and address/data ports.
module tb_mod_hash_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        m_we = 1'b0;
  logic [3:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  logic [2:0]  h_ra = '0;
  logic [31:0] h_rd;
  logic        busy, done, err;
  logic [7:0]  cmd;
  logic [7:0]  mka = '0;
  logic [7:0]  ha = 8'd8;
  logic [31:0] md, kd, hd_in;
  logic [31:0] hd_out = '0;
  logic        rdy = 1'b0;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [31:0] gen_m [16];
  logic [31:0] exp_h [8];

  mod_hash_seq dut (
    .CLK(clk), .RST(rst), .START(start), .M_WE(m_we), .M_WA(m_wa), .M_WD(m_wd),
    .H_RA(h_ra), .H_RD(h_rd), .BUSY(busy), .DONE(done), .ERR(err), .CMD(cmd),
    .MKA(mka), .HA(ha), .MD(md), .KD(kd), .HD_IN(hd_in), .HD_OUT(hd_out), .RDY(rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cmd !== 8'd0) begin errors++; $display("FAIL reset_cmd got=%h exp=00", cmd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    for (int i = 0; i < 8; i++) begin
      h_ra = i[2:0];
      #1;
      checks++;
      if (h_rd !== 32'd0) begin errors++; $display("FAIL reset_h_rd[%0d] got=%h exp=0", i, h_rd); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_serving();
    m_we = 1'b1; m_wa = 4'd1; m_wd = 32'h1234abcd;
    @(negedge clk);
    m_we = 1'b0;
    mka = 8'd17; #1;
    checks++; if (md !== 32'h1234abcd) begin errors++; $display("FAIL serve_md17 got=%h exp=1234abcd", md); end
    mka = 8'd63; #1;
    checks++; if (kd !== 32'hc67178f2) begin errors++; $display("FAIL serve_kd63 got=%h exp=c67178f2", kd); end
    mka = 8'd64; #1;
    checks++; if (kd !== 32'd0) begin errors++; $display("FAIL serve_kd64 got=%h exp=0", kd); end
    mka = 8'd0; #1;
    checks++; if (kd !== 32'h428a2f98) begin errors++; $display("FAIL serve_kd0 got=%h exp=428a2f98", kd); end
    ha = 8'd3; #1;
    checks++; if (hd_in !== 32'ha54ff53a) begin errors++; $display("FAIL serve_hd3 got=%h exp=a54ff53a", hd_in); end
    ha = 8'd7; #1;
    checks++; if (hd_in !== 32'h5be0cd19) begin errors++; $display("FAIL serve_hd7 got=%h exp=5be0cd19", hd_in); end
    ha = 8'd24; #1;
    checks++; if (hd_in !== 32'd0) begin errors++; $display("FAIL serve_hd24 got=%h exp=0", hd_in); end
    ha = 8'd8;
    @(negedge clk);
  endtask

  // Behavioural core: full genesis run, checking the CMD sequence on the way.
  task automatic test_genesis();
    logic [31:0] hv [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    int d0;
    for (int i = 0; i < 16; i++) begin
      m_we = 1'b1; m_wa = i[3:0]; m_wd = gen_m[i];
      @(negedge clk);
    end
    m_we = 1'b0;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (cmd !== 8'd1) begin errors++; $display("FAIL gen_cmd_load got=%h exp=01", cmd); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gen_busy got=%b exp=1", busy); end
    for (int i = 0; i < 8; i++) begin
      ha = i[7:0]; #1; hv[i] = hd_in;
      @(negedge clk);
    end
    ha = 8'd8; rdy = 1'b1;
    @(negedge clk);
    checks++; if (cmd !== 8'd0) begin errors++; $display("FAIL gen_cmd_gap1 got=%h exp=00", cmd); end
    rdy = 1'b0;
    @(negedge clk);
    checks++; if (cmd !== 8'd2) begin errors++; $display("FAIL gen_cmd_hash got=%h exp=02", cmd); end
    for (int i = 0; i < 16; i++) begin
      mka = i[7:0]; #1; w[i] = md;
      @(negedge clk);
    end
    for (int i = 16; i < 64; i++) begin
      w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7] + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    end
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int i = 0; i < 64; i++) begin
      mka = i[7:0]; #1;
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + kd + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      @(negedge clk);
    end
    mka = 8'd0; rdy = 1'b1;
    @(negedge clk);
    checks++; if (cmd !== 8'd0) begin errors++; $display("FAIL gen_cmd_gap2 got=%h exp=00", cmd); end
    rdy = 1'b0;
    @(negedge clk);
    checks++; if (cmd !== 8'd3) begin errors++; $display("FAIL gen_cmd_sum got=%h exp=03", cmd); end
    hv[0] = hv[0] + a; hv[1] = hv[1] + b; hv[2] = hv[2] + c; hv[3] = hv[3] + d;
    hv[4] = hv[4] + e; hv[5] = hv[5] + f; hv[6] = hv[6] + g; hv[7] = hv[7] + h;
    for (int i = 0; i < 8; i++) begin
      ha = i[7:0]; hd_out = hv[i];
      @(negedge clk);
    end
    ha = 8'd8; rdy = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cmd !== 8'd0) begin
      errors++; $display("FAIL gen_fin got done=%b busy=%b cmd=%h exp 1 0 00", done, busy, cmd);
    end
    rdy = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd !== 8'd0) begin
      errors++; $display("FAIL gen_idle got done=%b busy=%b cmd=%h exp 0 0 00", done, busy, cmd);
    end
    checks++; if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL gen_done_count got=%0d exp=1", done_cnt - d0);
    end
    for (int i = 0; i < 8; i++) begin
      h_ra = i[2:0]; #1;
      checks++;
      if (h_rd !== exp_h[i]) begin errors++; $display("FAIL gen_h[%0d] got=%h exp=%h", i, h_rd, exp_h[i]); end
    end
    ha = 8'd8; #1;
    checks++; if (hd_in !== exp_h[0]) begin errors++; $display("FAIL gen_hd_in8 got=%h exp=%h", hd_in, exp_h[0]); end
  endtask

  // START, M_WE and an RDY pulse while busy must all be ignored.
  task automatic test_ignored_while_busy();
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b1; m_we = 1'b1; m_wa = 4'd0; m_wd = 32'hdeadbeef;
    @(negedge clk);
    start = 1'b0; m_we = 1'b0;
    checks++; if (cmd !== 8'd1) begin errors++; $display("FAIL ign_cmd_load got=%h exp=01", cmd); end
    rdy = 1'b1;
    @(negedge clk);
    checks++; if (cmd !== 8'd0) begin errors++; $display("FAIL ign_gap1 got=%h exp=00", cmd); end
    rdy = 1'b0; #2 rdy = 1'b1; #1 rdy = 1'b0;
    @(negedge clk);
    checks++; if (cmd !== 8'd2) begin errors++; $display("FAIL ign_gap1_len got=%h exp=02", cmd); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cmd !== 8'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL ign_hash_hold got cmd=%h busy=%b exp 02 1", cmd, busy);
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    checks++; if (cmd !== 8'd3) begin errors++; $display("FAIL ign_cmd_sum got=%h exp=03", cmd); end
    rdy = 1'b1;
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    checks++; if (busy !== 1'b0 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL ign_finish got busy=%b dones=%0d exp 0 1", busy, done_cnt - d0);
    end
    mka = 8'd0; #1;
    checks++; if (md !== 32'h01000000) begin errors++; $display("FAIL ign_m0 got=%h exp=01000000", md); end
    h_ra = 3'd7; #1;
    checks++; if (h_rd !== exp_h[7]) begin errors++; $display("FAIL ign_h_retain got=%h exp=%h", h_rd, exp_h[7]); end
  endtask

  task automatic test_timeout();
    int n;
    int d0;
    d0 = done_cnt;
    n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cmd !== 8'd1) break;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 255) begin errors++; $display("FAIL to_cycles got=%0d exp=255", n); end
    checks++; if (err !== 1'b1 || cmd !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL to_state got err=%b cmd=%h busy=%b exp 1 00 0", err, cmd, busy);
    end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL to_no_done got=%0d exp=%0d", done_cnt, d0); end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", err); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (err !== 1'b0 || cmd !== 8'd1) begin
      errors++; $display("FAIL to_restart got err=%b cmd=%h exp 0 01", err, cmd);
    end
  endtask

  // Continues from the LOAD_H left running by test_timeout.
  task automatic test_reset_mid_hash();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    checks++; if (cmd !== 8'd2) begin errors++; $display("FAIL rst_pre_hash got=%h exp=02", cmd); end
    #2 rst = 1'b1;
    #1;
    checks++; if (cmd !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_abort got cmd=%h busy=%b exp 00 0", cmd, busy);
    end
    for (int i = 0; i < 8; i++) begin
      h_ra = i[2:0]; #0.1;
      checks++;
      if (h_rd !== 32'd0) begin errors++; $display("FAIL rst_h[%0d] got=%h exp=0", i, h_rd); end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd !== 8'd0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_after got cmd=%h busy=%b err=%b exp 00 0 0", cmd, busy, err);
    end
  endtask

  initial begin
    gen_m[0] = 32'h01000000;
    for (int i = 1; i < 9; i++) gen_m[i] = 32'h00000000;
    gen_m[9]  = 32'h3ba3edfd; gen_m[10] = 32'h7a7b12b2; gen_m[11] = 32'h7ac72c3e;
    gen_m[12] = 32'h67768f61; gen_m[13] = 32'h7fc81bc3; gen_m[14] = 32'h888a5132;
    gen_m[15] = 32'h3a9fb8aa;
    exp_h[0] = 32'hbc909a33; exp_h[1] = 32'h6358bff0; exp_h[2] = 32'h90ccac7d;
    exp_h[3] = 32'h1e59caa8; exp_h[4] = 32'hc3c8d8e9; exp_h[5] = 32'h4f0103c8;
    exp_h[6] = 32'h96b18736; exp_h[7] = 32'h4719f91b;

    test_reset();
    test_serving();
    test_genesis();
    test_ignored_while_busy();
    test_timeout();
    test_reset_mid_hash();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_hash_seq.md
MOD_HASH_SEQ -- requirements
Module: MOD_HASH_SEQ

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named as follows.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  host request to run one block.
- M_WE  in  1  message-buffer write enable.
- M_WA  in  4  message word address.
- M_WD  in  32  message word data.
- H_RA  in  3  result word select.
- H_RD  out  32  H[8+H_RA], combinational.
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky timeout flag.
- CMD  out  8  command to compression core.
- MKA  in  8  core message/K address.
- HA  in  8  core H address.
- MD  out  32  message word.
- KD  out  32  round constant.
- HD_IN  out  32  H word served to core.
- HD_OUT  in  32  summed H word from core.
- RDY  in  1  core command-complete, level.
REQ-002 SHALL use CMD encodings: IDLE=0, LOAD_H=1, HASH=2, SUM_STORE=3.

Function
REQ-003 SHALL hold a 16x32 message buffer M, a 64x32 K ROM holding the SHA-256 constants 0x428a2f98..0xc67178f2, and a 24x32 H bank.
REQ-004 SHALL hold H[0..7] as constants = SHA-256 IV (0x6a09e667..0x5be0cd19); H[8..23] SHALL be RAM.
REQ-005 SHALL drive combinationally: MD=M[MKA mod 16]; KD=K[MKA] for MKA<64, else 0; HD_IN=H[HA] for HA<24, else 0.
REQ-006 SHALL write M[M_WA]<=M_WD on M_WE only in IDLE; writes while BUSY SHALL be ignored.
REQ-007 SHALL implement FSM states IDLE, LOAD_H, GAP1, HASH, GAP2, SUM_STORE, FIN.
REQ-008 IDLE: CMD=0, BUSY=0; START=1 -> LOAD_H, BUSY=1 next cycle, ERR cleared.
REQ-009 LOAD_H/HASH/SUM_STORE SHALL drive CMD=1/2/3 and hold it until a RDY rising edge (RDY=1 while registered RDY_q=0).
REQ-010 On the RDY rising edge: LOAD_H->GAP1, HASH->GAP2, SUM_STORE->FIN.
REQ-011 GAP1/GAP2 SHALL drive CMD=0 for exactly one cycle, then go to HASH/SUM_STORE respectively.
REQ-012 FIN SHALL pulse DONE=1 for one cycle with CMD=0, then return to IDLE; BUSY SHALL fall in the same cycle DONE is high.
REQ-013 In SUM_STORE, each rising edge with HA<8 SHALL write H[HA+8]<=HD_OUT; HA>=8 SHALL not write.
REQ-014 START SHALL be ignored in every state except IDLE.
REQ-015 RDY edges in IDLE, GAP1, GAP2 or FIN SHALL be ignored.
REQ-016 SHALL keep an 8-bit watchdog, cleared on each command-state entry.
REQ-017 The watchdog SHALL increment each cycle in a command state; reaching 255 SHALL set ERR=1, force CMD=0, and return to IDLE without DONE.
REQ-018 H[8..23] SHALL retain their values across runs until reset or overwrite.

Reset
REQ-019 While RST=1, asynchronously: state=IDLE, CMD=0, BUSY=0, DONE=0, ERR=0, watchdog=0, RDY_q=0, H[8..23]=0, M[0..15]=0.
REQ-020 RST asserted mid-run SHALL abort immediately with the REQ-019 values; no partial store SHALL occur after RST rises.

Verification
REQ-021 Reset: assert RST -> CMD=0, BUSY=0, DONE=0, ERR=0, H_RD=0 for all H_RA.
REQ-022 Genesis block: load the Bitcoin genesis header first block, M[0]=0x01000000..M[15]=0x3a9fb8aa; START with a behavioral compression core. Required sequence CMD=1, 0, 2, 0, 3, 0; DONE pulses once. H_RA=0..7 reads 0xbc909a33, 0x6358bff0, 0x90ccac7d, 0x1e59caa8, 0xc3c8d8e9, 0x4f0103c8, 0x96b18736, 0x4719f91b.
REQ-023 Serving: in IDLE, MKA=17 -> MD=M[1]; MKA=63 -> KD=0xc67178f2; MKA=64 -> KD=0; HA=3 -> HD_IN=0xa54ff53a; HA=24 -> HD_IN=0.
REQ-024 Ignored events while BUSY: START pulse, M_WE to M[0]=0xdeadbeef, and RDY pulse in GAP1. Required: no restart, M[0] unchanged, GAP1 lasts exactly one cycle.
REQ-025 Timeout: core never asserts RDY after START. Required: ERR=1 and CMD=0 after 255 cycles in LOAD_H, state IDLE, no DONE; a following START clears ERR.
REQ-026 Reset mid-HASH: assert RST while CMD=2 -> CMD=0 and BUSY=0 immediately, H[8..15]=0.
